// File: rtl/pq_sorted_array.sv
`default_nettype none
// ============================================================================
// pq_sorted_array - sorted-array min priority queue, FIFO among equal keys.
// Remove-by-id support compiled only with PQ_DROP_EN defined.  Rev 1.0
// ============================================================================
module pq_sorted_array #(
    parameter int DEPTH  = 8,
    parameter int TIME_W = 16,
    parameter int ID_W   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [TIME_W-1:0]          push_data_i,
    input  logic [ID_W-1:0]            push_id_i,
    input  logic                       pop_i,
    input  logic                       drop_i,
    input  logic [ID_W-1:0]            drop_id_i,
    output logic                       head_valid_o,
    output logic [TIME_W-1:0]          head_data_o,
    output logic [ID_W-1:0]            head_id_o,
    output logic [$clog2(DEPTH+1)-1:0] cnt_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       drop_hit_o,
    output logic                       err_o
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [TIME_W-1:0] data_q  [DEPTH];
    logic [ID_W-1:0]   id_q    [DEPTH];
    logic [TIME_W-1:0] data_rm [DEPTH];
    logic [ID_W-1:0]   id_rm   [DEPTH];
    logic [TIME_W-1:0] data_nx [DEPTH];
    logic [ID_W-1:0]   id_nx   [DEPTH];

    logic             is_full;
    logic             is_empty;
    logic             do_pop;
    logic             do_push;
    logic             illegal;
    logic             hit;
    logic             rm;
    logic [CNT_W-1:0] rm_idx;
    logic [CNT_W-1:0] cnt_rm;
    logic [CNT_W-1:0] ins_pos;
    logic [CNT_W-1:0] cnt_nx;

    always_comb begin
        is_full  = (cnt_o == CNT_W'(DEPTH));
        is_empty = (cnt_o == '0);
        do_pop   = pop_i && !is_empty;
        do_push  = push_i && (!is_full || do_pop);
        illegal  = (push_i && !pop_i && is_full) || (pop_i && is_empty);
        hit      = 1'b0;
        rm_idx   = '0;
`ifdef PQ_DROP_EN
        if (drop_i) begin
            if (push_i || pop_i) begin
                illegal = 1'b1;
            end else begin
                // Scan downward so the lowest matching index wins.
                for (int i = DEPTH-1; i >= 0; i--) begin
                    if (i < int'(cnt_o) && id_q[i] == drop_id_i) begin
                        hit    = 1'b1;
                        rm_idx = CNT_W'(i);
                    end
                end
            end
        end
`endif
        // A pop removes cell 0 (rm_idx stays 0); a drop removes the matched cell.
        rm     = do_pop || hit;
        cnt_rm = rm ? cnt_o - 1'b1 : cnt_o;

        data_rm = data_q;
        id_rm   = id_q;
        for (int i = 0; i < DEPTH-1; i++) begin
            if (rm && i >= int'(rm_idx)) begin
                data_rm[i] = data_q[i+1];
                id_rm[i]   = id_q[i+1];
            end
        end

        // Insert after every entry whose key is <= the new key (FIFO among ties).
        ins_pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(cnt_rm) && data_rm[i] <= push_data_i) begin
                ins_pos = CNT_W'(i+1);
            end
        end

        data_nx = data_rm;
        id_nx   = id_rm;
        if (do_push) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (i > int'(ins_pos)) begin
                    data_nx[i] = data_rm[i-1];
                    id_nx[i]   = id_rm[i-1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(ins_pos)) begin
                    data_nx[i] = push_data_i;
                    id_nx[i]   = push_id_i;
                end
            end
        end
        cnt_nx = do_push ? cnt_rm + 1'b1 : cnt_rm;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o        <= '0;
            full_o       <= 1'b0;
            empty_o      <= 1'b1;
            head_valid_o <= 1'b0;
            head_data_o  <= '0;
            head_id_o    <= '0;
            err_o        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                id_q[i]   <= '0;
            end
        end else begin
            data_q       <= data_nx;
            id_q         <= id_nx;
            cnt_o        <= cnt_nx;
            full_o       <= (cnt_nx == CNT_W'(DEPTH));
            empty_o      <= (cnt_nx == '0);
            head_valid_o <= (cnt_nx != '0);
            head_data_o  <= (cnt_nx != '0) ? data_nx[0] : '0;
            head_id_o    <= (cnt_nx != '0) ? id_nx[0] : '0;
            err_o        <= illegal;
        end
    end

`ifdef PQ_DROP_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_hit_o <= 1'b0;
        end else begin
            drop_hit_o <= hit;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = ^{drop_i, drop_id_i, hit, rm_idx};
    assign drop_hit_o  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pq_sorted_array.sv
`default_nettype none
// tb_pq_sorted_array - vector table, drop/reset sequences and randomized
// comparison against a queue-based reference model (DEPTH=4).
module tb_pq_sorted_array;

    localparam int DEPTH = 4;
    localparam int TW    = 16;
    localparam int IW    = 16;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          drop = 1'b0;
    logic [TW-1:0] push_data = '0;
    logic [IW-1:0] push_id = '0;
    logic [IW-1:0] drop_id = '0;
    logic          head_valid;
    logic [TW-1:0] head_data;
    logic [IW-1:0] head_id;
    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          drop_hit;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [TW-1:0] d;
        logic [IW-1:0] id;
    } entry_t;
    entry_t mq[$];

    typedef struct {
        bit rst;
        bit pu;
        int pd;
        int pid;
        bit po;
        bit ev;
        int ed;
        int eid;
        int ecnt;
        bit eerr;
    } vec_t;
    vec_t tbl[$];

    pq_sorted_array #(.DEPTH(DEPTH), .TIME_W(TW), .ID_W(IW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .push_i       (push),
        .push_data_i  (push_data),
        .push_id_i    (push_id),
        .pop_i        (pop),
        .drop_i       (drop),
        .drop_id_i    (drop_id),
        .head_valid_o (head_valid),
        .head_data_o  (head_data),
        .head_id_o    (head_id),
        .cnt_o        (cnt),
        .full_o       (full),
        .empty_o      (empty),
        .drop_hit_o   (drop_hit),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(bit rst, bit pu, int pd, int pid, bit po,
                                bit ev, int ed, int eid, int ecnt, bit eerr);
        vec_t v;
        v.rst = rst; v.pu = pu; v.pd = pd; v.pid = pid; v.po = po;
        v.ev = ev; v.ed = ed; v.eid = eid; v.ecnt = ecnt; v.eerr = eerr;
        return v;
    endfunction

    task automatic check(input string name, input bit ev, input int ed, input int eid,
                         input int ecnt, input bit eerr, input bit ehit);
        logic [TW+IW+CW+4:0] got;
        logic [TW+IW+CW+4:0] exp;
        got = {head_valid, head_data, head_id, cnt, full, empty, drop_hit, err};
        exp = {ev, TW'(ed), IW'(eid), CW'(ecnt), ecnt == DEPTH, ecnt == 0, ehit, eerr};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got v=%0b d=%0d id=%0d cnt=%0d full=%0b empty=%0b hit=%0b err=%0b; want v=%0b d=%0d id=%0d cnt=%0d hit=%0b err=%0b",
                     name, head_valid, head_data, head_id, cnt, full, empty, drop_hit, err,
                     ev, ed, eid, ecnt, ehit, eerr);
        end
    endtask

    task automatic step(input bit pu, input int pd, input int pid,
                        input bit po, input bit dr, input int did);
        push = pu; push_data = TW'(pd); push_id = IW'(pid);
        pop = po; drop = dr; drop_id = IW'(did);
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; drop = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        mq.delete();
    endtask

    // Reference: pop first, then insert before the first strictly larger key.
    task automatic model(input bit pu, input int pd, input int pid, input bit po,
                         input bit dr, input int did, output bit eerr, output bit ehit);
        int sz;
        int pos;
        entry_t e;
        sz = mq.size();
        eerr = 1'b0;
        ehit = 1'b0;
        if (po && sz == 0) eerr = 1'b1;
        if (pu && !po && sz == DEPTH) eerr = 1'b1;
`ifdef PQ_DROP_EN
        if (dr && (pu || po)) eerr = 1'b1;
`endif
        if (po && sz > 0) void'(mq.pop_front());
        if (pu && (sz < DEPTH || (po && sz > 0))) begin
            pos = mq.size();
            for (int i = 0; i < mq.size(); i++) begin
                if (int'(mq[i].d) > pd) begin
                    pos = i;
                    break;
                end
            end
            e.d = TW'(pd);
            e.id = IW'(pid);
            mq.insert(pos, e);
        end
`ifdef PQ_DROP_EN
        if (dr && !pu && !po) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (int'(mq[i].id) == did) begin
                    mq.delete(i);
                    ehit = 1'b1;
                    break;
                end
            end
        end
`else
        if (dr && did < 0) ehit = 1'b0;
`endif
    endtask

    initial begin
        bit pu, po, dr, eerr, ehit;
        int pd, pid, did;

        // rst pu pd pid po | ev ed eid cnt err
        tbl.push_back(mk(1, 0,  0,  0, 0,  0,  0,  0, 0, 0));
        tbl.push_back(mk(0, 1, 30,  1, 0,  1, 30,  1, 1, 0));
        tbl.push_back(mk(0, 1, 10,  2, 0,  1, 10,  2, 2, 0));
        tbl.push_back(mk(0, 1, 20,  3, 0,  1, 10,  2, 3, 0));
        tbl.push_back(mk(0, 0,  0,  0, 1,  1, 20,  3, 2, 0));
        tbl.push_back(mk(0, 0,  0,  0, 1,  1, 30,  1, 1, 0));
        tbl.push_back(mk(0, 0,  0,  0, 1,  0,  0,  0, 0, 0));
        tbl.push_back(mk(0, 1,  5,  1, 0,  1,  5,  1, 1, 0));
        tbl.push_back(mk(0, 1,  5,  2, 0,  1,  5,  1, 2, 0));
        tbl.push_back(mk(0, 0,  0,  0, 1,  1,  5,  2, 1, 0));
        tbl.push_back(mk(0, 0,  0,  0, 1,  0,  0,  0, 0, 0));
        tbl.push_back(mk(0, 1,  1,  1, 0,  1,  1,  1, 1, 0));
        tbl.push_back(mk(0, 1,  2,  2, 0,  1,  1,  1, 2, 0));
        tbl.push_back(mk(0, 1,  3,  3, 0,  1,  1,  1, 3, 0));
        tbl.push_back(mk(0, 1,  4,  4, 0,  1,  1,  1, 4, 0));
        tbl.push_back(mk(0, 1,  9,  9, 0,  1,  1,  1, 4, 1));
        tbl.push_back(mk(0, 1,  0, 10, 1,  1,  0, 10, 4, 0));
        tbl.push_back(mk(0, 0,  0,  0, 1,  1,  2,  2, 3, 0));
        tbl.push_back(mk(0, 0,  0,  0, 1,  1,  3,  3, 2, 0));
        tbl.push_back(mk(0, 0,  0,  0, 1,  1,  4,  4, 1, 0));
        tbl.push_back(mk(0, 0,  0,  0, 1,  0,  0,  0, 0, 0));
        tbl.push_back(mk(0, 0,  0,  0, 1,  0,  0,  0, 0, 1));
        tbl.push_back(mk(0, 1,  7,  7, 1,  1,  7,  7, 1, 1));
        tbl.push_back(mk(0, 0,  0,  0, 1,  0,  0,  0, 0, 0));

        @(posedge clk);
        #1;
        for (int k = 0; k < tbl.size(); k++) begin
            if (tbl[k].rst) do_reset();
            else step(tbl[k].pu, tbl[k].pd, tbl[k].pid, tbl[k].po, 1'b0, 0);
            check($sformatf("vec%0d", k), tbl[k].ev, tbl[k].ed, tbl[k].eid,
                  tbl[k].ecnt, tbl[k].eerr, 1'b0);
        end

`ifdef PQ_DROP_EN
        do_reset();
        step(1, 10, 1, 0, 0, 0); check("drop_fill1", 1, 10, 1, 1, 0, 0);
        step(1, 20, 2, 0, 0, 0); check("drop_fill2", 1, 10, 1, 2, 0, 0);
        step(1, 30, 3, 0, 0, 0); check("drop_fill3", 1, 10, 1, 3, 0, 0);
        step(0, 0, 0, 0, 1, 2);  check("drop_hit",   1, 10, 1, 2, 0, 1);
        step(0, 0, 0, 0, 1, 9);  check("drop_miss",  1, 10, 1, 2, 0, 0);
        step(0, 0, 0, 1, 0, 0);  check("drop_pop",   1, 30, 3, 1, 0, 0);
        step(1, 40, 4, 0, 0, 0); check("drop_push",  1, 30, 3, 2, 0, 0);
        step(0, 0, 0, 1, 1, 4);  check("drop_w_pop", 1, 40, 4, 1, 1, 0);
        step(1, 50, 5, 0, 1, 4); check("drop_w_push", 1, 40, 4, 2, 1, 0);
        step(0, 0, 0, 0, 1, 4);  check("drop_head",  1, 50, 5, 1, 0, 1);
        do_reset();
        step(1, 5, 7, 0, 0, 0);
        step(1, 6, 7, 0, 0, 0);
        step(0, 0, 0, 0, 1, 7);  check("drop_lowest", 1, 6, 7, 1, 0, 1);
`else
        do_reset();
        step(1, 30, 1, 0, 1, 1); check("nodrop_p1", 1, 30, 1, 1, 0, 0);
        step(1, 10, 2, 0, 1, 2); check("nodrop_p2", 1, 10, 2, 2, 0, 0);
        step(1, 20, 3, 0, 1, 3); check("nodrop_p3", 1, 10, 2, 3, 0, 0);
        step(0, 0, 0, 0, 1, 2);  check("nodrop_d",  1, 10, 2, 3, 0, 0);
        step(0, 0, 0, 1, 1, 3);  check("nodrop_q1", 1, 20, 3, 2, 0, 0);
        step(0, 0, 0, 1, 1, 1);  check("nodrop_q2", 1, 30, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1, 1);  check("nodrop_q3", 0, 0, 0, 0, 0, 0);
`endif

        // Asynchronous reset with three entries stored, checked between edges.
        do_reset();
        step(1, 10, 1, 0, 0, 0);
        step(1, 20, 2, 0, 0, 0);
        step(1, 30, 3, 1, 0, 0);
        check("pre_reset", 1, 20, 2, 2, 0, 0);
        step(1, 40, 4, 0, 0, 0);
        check("pre_reset3", 1, 20, 2, 3, 0, 0);
        step(1, 50, 5, 1, 1, 9);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        mq.delete();
        @(posedge clk);
        #1;
        check("post_reset_idle", 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);  check("post_reset_pop", 0, 0, 0, 0, 1, 0);
        step(1, 7, 7, 0, 0, 0);  check("post_reset_push", 1, 7, 7, 1, 0, 0);

        // Randomized traffic against the reference queue.
        do_reset();
        check("rand_reset", 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
                check("rand_reset_mid", 0, 0, 0, 0, 0, 0);
                continue;
            end
            pu  = ($urandom_range(99) < 55);
            po  = ($urandom_range(99) < 35);
            dr  = ($urandom_range(99) < 25);
            pd  = int'($urandom_range(15));
            pid = int'($urandom_range(7));
            did = int'($urandom_range(7));
            model(pu, pd, pid, po, dr, did, eerr, ehit);
            step(pu, pd, pid, po, dr, did);
            if (mq.size() > 0)
                check($sformatf("rand%0d", k), 1'b1, int'(mq[0].d), int'(mq[0].id),
                      mq.size(), eerr, ehit);
            else
                check($sformatf("rand%0d", k), 1'b0, 0, 0, 0, eerr, ehit);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
